spi_nor_responder: RTL

Synthesisable SPI NOR flash responder: the slave end of the SPI link driven by the APB-to-SPI controller. It decodes a subset of standard NOR opcodes, covering write enable/disable, status read, JEDEC ID, read and page program, against an internal byte array. The block serves as the flash-side model in system simulation and FPGA loopback builds. It runs entirely in the p_clk domain and oversamples the SPI pins.

---
 rtl/spi_nor_pkg.sv | 40 ++++
 rtl/spi_nor_responder_sync.sv | 39 +++
 rtl/spi_nor_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_nor_pkg.sv
// Shared opcodes, state encoding and status register layout for the SPI NOR responder.
package spi_nor_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;

    localparam int unsigned SR_WIP = 0;
    localparam int unsigned SR_WEL = 1;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRead,
        StProg,
        StStatus,
        StId,
        StIgnore
    } state_e;

    // Latch update deferred until chip select rises, so the exact bit count can be confirmed.
    typedef enum logic [1:0] {
        PendNone,
        PendWren,
        PendWrdi
    } pend_e;

    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] sb;
        sb         = 8'h00;
        sb[SR_WIP] = 1'b0;
        sb[SR_WEL] = wel;
        return sb;
    endfunction

endpackage

// File: rtl/spi_nor_responder_sync.sv
// Two-flop synchronisers for the SPI pins plus edge strobes of s_clk and s_css.
module spi_edge_sync (
    input  logic p_clk,
    input  logic p_reset_n,
    input  logic s_clk,
    input  logic s_css,
    input  logic s_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic css_rise,
    output logic css_fall,
    output logic mosi_sync
);

    logic [2:0] sclk_q;
    logic [2:0] css_q;
    logic [1:0] mosi_q;

    // Chip select resets to "asserted" so a select already low at reset release never looks
    // like a fresh transaction start.
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            sclk_q <= 3'b000;
            css_q  <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], s_clk};
            css_q  <= {css_q[1:0], s_css};
            mosi_q <= {mosi_q[0], s_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign css_rise  = css_q[1] & ~css_q[2];
    assign css_fall  = ~css_q[1] & css_q[2];
    assign mosi_sync = mosi_q[1];

endmodule

// File: rtl/spi_nor_responder.sv
// SPI NOR flash responder: oversamples the SPI pins on p_clk and serves a small opcode set.
module spi_nor_responder
    import spi_nor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
    input  logic p_clk,
    input  logic p_reset_n,
    input  logic s_clk,
    input  logic s_css,
    input  logic s_mosi,
    output logic s_miso,
    output logic s_miso_oe,
    output logic wel
);

    localparam logic [ADDR_WIDTH-1:0] PageMask = ADDR_WIDTH'(255);

    logic sclk_rise, sclk_fall, css_rise, css_fall, mosi_sync;

    spi_edge_sync u_sync (
        .p_clk     (p_clk),
        .p_reset_n (p_reset_n),
        .s_clk     (s_clk),
        .s_css     (s_css),
        .s_mosi    (s_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .css_rise  (css_rise),
        .css_fall  (css_fall),
        .mosi_sync (mosi_sync)
    );

    state_e                state_q;
    pend_e                 pend_q;
    logic [2:0]            bit_cnt_q;
    logic [1:0]            byte_cnt_q;
    logic [1:0]            id_idx_q;
    logic [7:0]            sh_in_q;
    logic [7:0]            opcode_q;
    logic [7:0]            tx_sh_q;
    logic [7:0]            rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  miso_q;
    logic                  oe_q;
    logic                  wel_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]            wr_data_q;

    logic [7:0] mem [2**ADDR_WIDTH];

    logic [7:0]            in_byte;
    logic                  byte_done;
    logic [ADDR_WIDTH-1:0] addr_page_inc;
    logic [7:0]            next_tx;

    assign in_byte       = {sh_in_q[6:0], mosi_sync};
    assign byte_done     = sclk_rise && (bit_cnt_q == 3'd7);
    assign addr_page_inc = (addr_q & ~PageMask) | ((addr_q + ADDR_WIDTH'(1)) & PageMask);

    always_comb begin
        next_tx = 8'h00;
        unique case (state_q)
            StStatus: next_tx = status_byte(wel_q);
            StId: begin
                unique case (id_idx_q)
                    2'd0:    next_tx = JEDEC_ID[23:16];
                    2'd1:    next_tx = JEDEC_ID[15:8];
                    2'd2:    next_tx = JEDEC_ID[7:0];
                    default: next_tx = 8'h00;
                endcase
            end
            StRead:  next_tx = rd_q;
            default: next_tx = 8'h00;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (wr_en_q) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            state_q    <= StIdle;
            pend_q     <= PendNone;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            id_idx_q   <= 2'd0;
            sh_in_q    <= 8'h00;
            opcode_q   <= 8'h00;
            tx_sh_q    <= 8'h00;
            rd_q       <= 8'h00;
            addr_q     <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            wel_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            wr_en_q <= 1'b0;
            // Continuous fetch keeps rd_q one cycle behind addr_q, well ahead of the next fall.
            rd_q    <= mem[addr_q];
            if (css_rise) begin
                if (state_q == StIgnore) begin
                    unique case (pend_q)
                        PendWren: wel_q <= 1'b1;
                        PendWrdi: wel_q <= 1'b0;
                        default:  ;
                    endcase
                end
                if (state_q == StProg) begin
                    wel_q <= 1'b0;
                end
                state_q   <= StIdle;
                pend_q    <= PendNone;
                bit_cnt_q <= 3'd0;
                oe_q      <= 1'b0;
                miso_q    <= 1'b0;
            end else if (css_fall) begin
                state_q    <= StCmd;
                pend_q     <= PendNone;
                byte_cnt_q <= 2'd0;
                id_idx_q   <= 2'd0;
                addr_q     <= '0;
                oe_q       <= 1'b0;
                miso_q     <= 1'b0;
                // A coincident rising strobe is the first opcode bit.
                if (sclk_rise) begin
                    bit_cnt_q <= 3'd1;
                    sh_in_q   <= in_byte;
                end else begin
                    bit_cnt_q <= 3'd0;
                end
            end else if (state_q != StIdle) begin
                if (sclk_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    sh_in_q   <= in_byte;
                    unique case (state_q)
                        StCmd: begin
                            if (bit_cnt_q == 3'd7) begin
                                opcode_q <= in_byte;
                                case (in_byte)
                                    OP_WREN: begin
                                        state_q <= StIgnore;
                                        pend_q  <= PendWren;
                                    end
                                    OP_WRDI: begin
                                        state_q <= StIgnore;
                                        pend_q  <= PendWrdi;
                                    end
                                    OP_RDSR: begin
                                        state_q <= StStatus;
                                        oe_q    <= 1'b1;
                                    end
                                    OP_RDID: begin
                                        state_q <= StId;
                                        oe_q    <= 1'b1;
                                    end
                                    OP_READ, OP_PP: state_q <= StAddr;
                                    default:        state_q <= StIgnore;
                                endcase
                            end
                        end
                        StAddr: begin
                            addr_q <= {addr_q[ADDR_WIDTH-2:0], mosi_sync};
                            if (byte_done) begin
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (byte_cnt_q == 2'd2) begin
                                    if (opcode_q == OP_READ) begin
                                        state_q <= StRead;
                                        oe_q    <= 1'b1;
                                    end else begin
                                        state_q <= StProg;
                                    end
                                end
                            end
                        end
                        StRead: begin
                            if (byte_done) begin
                                addr_q <= addr_q + ADDR_WIDTH'(1);
                            end
                        end
                        StProg: begin
                            if (byte_done) begin
                                if (wel_q) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= addr_q;
                                    wr_data_q <= in_byte;
                                end
                                addr_q <= addr_page_inc;
                            end
                        end
                        StIgnore: pend_q <= PendNone;
                        default:  ;
                    endcase
                end else if (sclk_fall && oe_q) begin
                    if (bit_cnt_q == 3'd0) begin
                        miso_q  <= next_tx[7];
                        tx_sh_q <= {next_tx[6:0], 1'b0};
                        if (state_q == StId && id_idx_q != 2'd3) begin
                            id_idx_q <= id_idx_q + 2'd1;
                        end
                    end else begin
                        miso_q  <= tx_sh_q[7];
                        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Drop the drive in the very cycle the chip-select rise is seen.
    assign s_miso_oe = oe_q & ~css_rise;
    assign s_miso    = s_miso_oe & miso_q;
    assign wel       = wel_q;

endmodule
